// File: rtl/regfile_wport_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_wport_arb_pkg;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned WAIT_CNT_W   = 3;
    localparam int unsigned STALL_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

endpackage : regfile_wport_arb_pkg

// File: rtl/regfile_wport_arb.sv
// Arbitrates the single register-file write port between the W stage and the
// multi-cycle unit. W always wins; a starved MDU result eventually forces a
// pipeline stall so it can drain.
module regfile_wport_arb
    import regfile_wport_arb_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEFAULT,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   reg_write_w,
    input  logic [REG_ADDR_W-1:0]  rd_w,
    input  logic [XLEN-1:0]        result_w,
    input  logic                   mdu_valid,
    input  logic [REG_ADDR_W-1:0]  mdu_rd,
    input  logic [XLEN-1:0]        mdu_data,
    output logic                   mdu_ready,
    output logic                   rf_we,
    output logic [REG_ADDR_W-1:0]  rf_waddr,
    output logic [XLEN-1:0]        rf_wdata,
    output logic                   stall_req,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(STARVE_LIMIT - 1);

    arb_state_t              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    stall_req_q, stall_req_d;
    logic [STALL_CNT_W-1:0]  stall_count_q, stall_count_d;

    logic pipe_use;
    logic grant;
    logic blocked;
    logic enter_force;

    // A W-stage write to x0 does not occupy the port; reset suppresses all handshakes.
    always_comb begin
        pipe_use = reg_write_w && (rd_w != '0);
        grant    = mdu_valid && !pipe_use && !rst;
        blocked  = mdu_valid && pipe_use;
    end

    // Write-port mux: W first, then a granted MDU result (x0 accepted but not written).
    always_comb begin
        mdu_ready = grant;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        if (pipe_use && !rst) begin
            rf_we    = 1'b1;
            rf_waddr = rd_w;
            rf_wdata = result_w;
        end else if (grant && (mdu_rd != '0)) begin
            rf_we    = 1'b1;
            rf_waddr = mdu_rd;
            rf_wdata = mdu_data;
        end
    end

    // Starvation FSM next-state: count blocked cycles, escalate to a forced stall.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        enter_force = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (blocked) begin
                    if (STARVE_LIMIT == 1) begin
                        state_d     = FORCE;
                        enter_force = 1'b1;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (grant || !mdu_valid) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = FORCE;
                    enter_force = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end
            end
            FORCE: begin
                if (grant || !mdu_valid) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
        stall_req_d   = (state_d == FORCE);
        stall_count_d = stall_count_q;
        if (enter_force && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            stall_req_q   <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_req_q   <= stall_req_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_req   = stall_req_q;
    assign stall_count = stall_count_q;

endmodule : regfile_wport_arb

// File: tb/tb_regfile_wport_arb.sv
// Self-checking bench for regfile_wport_arb: vector table plus starvation and reset sequences.
module tb_regfile_wport_arb;
    import regfile_wport_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;

    logic        mdu_ready, rf_we, stall_req;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] stall_count;

    logic        mdu_ready_l1, rf_we_l1, stall_req_l1;
    logic [4:0]  rf_waddr_l1;
    logic [31:0] rf_wdata_l1;
    logic [15:0] stall_count_l1;

    int errors = 0;
    int checks = 0;

    regfile_wport_arb #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_req(stall_req), .stall_count(stall_count)
    );

    regfile_wport_arb #(.XLEN(32), .STARVE_LIMIT(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready_l1), .rf_we(rf_we_l1), .rf_waddr(rf_waddr_l1), .rf_wdata(rf_wdata_l1),
        .stall_req(stall_req_l1), .stall_count(stall_count_l1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ready;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        exp_t        e;
    } vec_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs for one cycle and queue the expected write-port result.
    task automatic drive(input logic wr, input logic [4:0] rd, input logic [31:0] res,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                         input exp_t e);
        reg_write_w = wr;  rd_w   = rd;  result_w = res;
        mdu_valid   = mv;  mdu_rd = mrd; mdu_data = mdat;
        exp_q.push_back(e);
    endtask

    // Sample mid-cycle, compare against the oldest queued expectation, advance.
    task automatic sample(input string tag);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".we"},    32'(rf_we),     32'(e.we));
            chk({tag, ".waddr"}, 32'(rf_waddr),  32'(e.waddr));
            chk({tag, ".wdata"}, rf_wdata,       e.wdata);
            chk({tag, ".ready"}, 32'(mdu_ready), 32'(e.ready));
        end
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic we, input logic [4:0] a, input logic [31:0] d,
                                input logic r);
        exp_t e;
        e.we = we; e.waddr = a; e.wdata = d; e.ready = r;
        return e;
    endfunction

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 5'd5, 32'h11,   1'b0, 5'd0, 32'h0,  mk(1'b1, 5'd5, 32'h11, 1'b0)};
        vecs[1] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  mk(1'b0, 5'd0, 32'h0, 1'b0)};
        vecs[2] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'hAB, mk(1'b1, 5'd7, 32'hAB, 1'b1)};
        vecs[3] = '{1'b1, 5'd0, 32'h55,   1'b1, 5'd3, 32'h33, mk(1'b1, 5'd3, 32'h33, 1'b1)};
        vecs[4] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'h99, mk(1'b0, 5'd0, 32'h0, 1'b1)};
        vecs[5] = '{1'b1, 5'd9, 32'hDEAD, 1'b1, 5'd4, 32'h44, mk(1'b1, 5'd9, 32'hDEAD, 1'b0)};
        vecs[6] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd4, 32'h44, mk(1'b1, 5'd4, 32'h44, 1'b1)};
        vecs[7] = '{1'b1, 5'd0, 32'h77,   1'b0, 5'd0, 32'h0,  mk(1'b0, 5'd0, 32'h0, 1'b0)};

        // Reset with an MDU request pending: no write, no accept.
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22, mk(1'b0, 5'd0, 32'h0, 1'b0));
        @(posedge clk); #1;
        sample("reset");
        rst = 1'b0;
        chk("reset.stall_req",   32'(stall_req),   32'h0);
        chk("reset.stall_count", 32'(stall_count), 32'h0);

        // Single-cycle arbitration table.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].res, vecs[i].mv, vecs[i].mrd, vecs[i].mdat,
                  vecs[i].e);
            sample($sformatf("vec%0d", i));
            if (i == 2) chk("vec2.state_idle", 32'(dut.state_q), 32'(IDLE));
        end
        chk("table.stall_count",    32'(stall_count),    32'h0);
        chk("table.stall_count_l1", 32'(stall_count_l1), 32'h1);

        // Starvation: W writes x1 every cycle while the MDU holds x6.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd1, 32'(100 + k), 1'b1, 5'd6, 32'h66,
                  mk(1'b1, 5'd1, 32'(100 + k), 1'b0));
            chk($sformatf("starve%0d.stall_req", k), 32'(stall_req), 32'h0);
            if (k == 1) chk("starve1.stall_req_l1", 32'(stall_req_l1), 32'h1);
            sample($sformatf("starve%0d", k));
        end
        chk("starve.stall_req_up",  32'(stall_req),   32'h1);
        chk("starve.stall_count_1", 32'(stall_count), 32'h1);
        drive(1'b1, 5'd1, 32'h104, 1'b1, 5'd6, 32'h66, mk(1'b1, 5'd1, 32'h104, 1'b0));
        sample("force_hold");
        chk("force_hold.stall_req", 32'(stall_req), 32'h1);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, mk(1'b1, 5'd6, 32'h66, 1'b1));
        sample("force_bubble");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, mk(1'b0, 5'd0, 32'h0, 1'b0));
        chk("drain.stall_req",   32'(stall_req),      32'h0);
        chk("drain.state_idle",  32'(dut.state_q),    32'(IDLE));
        chk("drain.stall_count", 32'(stall_count),    32'h1);
        sample("drain");

        // Re-enter FORCE, then reset in the middle of it.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd2, 32'(200 + k), 1'b1, 5'd8, 32'h88,
                  mk(1'b1, 5'd2, 32'(200 + k), 1'b0));
            sample($sformatf("refill%0d", k));
        end
        chk("refill.stall_req",   32'(stall_req),   32'h1);
        chk("refill.stall_count", 32'(stall_count), 32'h2);
        rst = 1'b1;
        drive(1'b1, 5'd0, 32'h5, 1'b1, 5'd8, 32'h88, mk(1'b0, 5'd0, 32'h0, 1'b0));
        sample("rst_in_force");
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, mk(1'b0, 5'd0, 32'h0, 1'b0));
        chk("post_rst.stall_req",   32'(stall_req),   32'h0);
        chk("post_rst.state_idle",  32'(dut.state_q), 32'(IDLE));
        chk("post_rst.stall_count", 32'(stall_count), 32'h0);
        sample("post_rst");

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_wport_arb

// File: doc/regfile_wport_arb.md
REGFILE_WPORT_ARB -- requirements
Module: regfile_wport_arb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, the register data width.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, legal range 1..7: the number of consecutive blocked MDU cycles before a pipeline stall is forced.
REQ-003 Ports SHALL be:
  clk  in  1  clock, all state on rising edge
  rst  in  1  reset, synchronous, active-high
  reg_write_w  in  1  W-stage write enable
  rd_w  in  5  W-stage destination register
  result_w  in  XLEN  W-stage write data
  mdu_valid  in  1  multi-cycle unit (MDU) result valid
  mdu_rd  in  5  MDU destination register
  mdu_data  in  XLEN  MDU result data
  mdu_ready  out  1  MDU result accepted this cycle
  rf_we  out  1  register-file write enable
  rf_waddr  out  5  register-file write address
  rf_wdata  out  XLEN  register-file write data
  stall_req  out  1  registered request to the hazard unit to stall the pipeline and bubble W
  stall_count  out  16  saturating count of forced stalls

Function
REQ-004 The block SHALL arbitrate the single register-file write port between the W stage and the MDU.
REQ-005 pipe_use SHALL be reg_write_w AND (rd_w != 0); a W-stage write to x0 SHALL NOT occupy the port.
REQ-006 grant SHALL be mdu_valid AND NOT pipe_use, combinational; mdu_ready SHALL equal grant.
REQ-007 If pipe_use is 1, rf_we=1, rf_waddr=rd_w, rf_wdata=result_w.
REQ-008 Otherwise, if grant is 1 and mdu_rd != 0, rf_we=1, rf_waddr=mdu_rd, rf_wdata=mdu_data.
REQ-009 A granted MDU result with mdu_rd=0 SHALL be accepted (mdu_ready=1) with rf_we=0.
REQ-010 Otherwise rf_we=0, and rf_waddr and rf_wdata SHALL be 0.
REQ-011 The W stage SHALL always win a simultaneous request; the W stage is never back-pressured combinationally.
REQ-012 MDU handshake: the MDU holds mdu_valid, mdu_rd and mdu_data stable until mdu_ready; transfer occurs on the cycle where mdu_valid and mdu_ready are both 1.
REQ-013 FSM states SHALL be IDLE, WAIT and FORCE.
REQ-014 IDLE transitions: mdu_valid and blocked -> WAIT with wait_cnt=1; otherwise stay IDLE.
REQ-015 WAIT transitions: grant -> IDLE with wait_cnt=0; blocked with wait_cnt=STARVE_LIMIT-1 -> FORCE; blocked otherwise -> wait_cnt+1.
REQ-016 FORCE transitions: grant -> IDLE with wait_cnt=0; otherwise stay FORCE (fail-safe: the pipeline still wins if it writes anyway).
REQ-017 stall_req SHALL be a register equal to 1 exactly while the state is FORCE.
REQ-018 stall_count SHALL increment on each IDLE/WAIT->FORCE transition and saturate at 16'hFFFF.
REQ-019 Hazard-unit contract: after stall_req rises, W presents reg_write_w=0 by the next cycle, which guarantees the MDU grant.
REQ-020 If STARVE_LIMIT=1, the first blocked cycle SHALL go IDLE->FORCE directly.
REQ-021 If mdu_valid drops without a grant, which is a protocol violation, the state SHALL return to IDLE and wait_cnt SHALL become 0.

Reset
REQ-022 While rst=1 at a clock edge, the state SHALL become IDLE, wait_cnt 0, stall_req 0 and stall_count 0.
REQ-023 While rst is high, rf_we and mdu_ready SHALL be forced to 0, including a reset asserted mid-WAIT or mid-FORCE.

Structure
REQ-024 A shared package SHALL hold the FSM state enum (arb_state_t), the REG_ADDR_W=5 constant and the XLEN default.
REQ-025 The implementation SHALL be a single module with no sub-modules; the write mux and the FSM are both internal to it.

Verification
REQ-026 W writes x5=0x11 while mdu_valid is low -> rf_we=1, waddr=5, wdata=0x11, mdu_ready=0.
REQ-027 mdu_valid with rd=7, data=0xAB while W is idle -> same-cycle mdu_ready=1, rf write x7=0xAB, state stays IDLE.
REQ-028 W writes rd=0 while the MDU presents rd=3 -> MDU granted, x3 written.
REQ-029 STARVE_LIMIT=4 with W writing x1 every cycle and mdu_valid held -> stall_req=1 in the cycle after the 4th blocked cycle; the bench bubbles W the next cycle; the MDU is written that cycle; stall_count=1; the FSM returns to IDLE.
REQ-030 rst asserted while in FORCE -> next cycle stall_req=0, state IDLE, stall_count=0, and no rf_we during reset.
REQ-031 The MDU is granted with rd=0 -> mdu_ready=1 and rf_we=0.
